// File: rtl/branch_predict_ctrl_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter values and redirect FSM states.
// The BR_* func3 codes are decoded upstream by the branch control unit, so none appear here.
package branch_predict_ctrl_pkg;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REDIR   = 2'b01,
    ST_RECOVER = 2'b10
  } state_e;

  // Saturating step of a bimodal counter towards taken (up=1) or not-taken (up=0)
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
    logic [1:0] nxt;
    nxt = ctr;
    if (up) begin
      if (ctr != STRONG_T) nxt = ctr + 2'd1;
    end else begin
      if (ctr != STRONG_NT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht_counter_table.sv
// Bimodal history table: 2^IDX_W saturating 2-bit counters with one combinational
// read port and one clocked saturating update port (read returns the pre-update value).
module bht_counter_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];

  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) ctr_d[wr_idx] = sat_update(ctr_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= WEAK_NT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor and redirect controller: bimodal prediction for fetch, training from EX,
// and a one-cycle redirect/flush sequence (holdable by stall) on every mispredict.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      lookup_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic             ex_taken,
  input  logic             stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] mispredict_cnt
);

  state_e             state_q, state_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;
  logic [1:0]         rd_ctr;
  logic               res;
  logic               mis;
  logic               in_redir;
  logic               unused_bits;

  // Only IDLE resolves: during RECOVER the EX slot holds a wrong-path instruction
  assign res = ex_valid & ex_is_branch & ~stall & (state_q == ST_IDLE);
  assign mis = res & (ex_pred_taken != ex_taken);

  bht_counter_table #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lookup_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (res),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (ex_taken)
  );

  assign pred_taken  = rd_ctr[1];
  assign unused_bits = ^{rd_ctr[0], lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    mis_cnt_d     = mis_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mis) begin
          state_d       = ST_REDIR;
          redirect_pc_d = ex_taken ? ex_target : (ex_pc + 32'd4);
        end
      end
      ST_REDIR:   if (!stall) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (mis && (mis_cnt_q != {CNT_W{1'b1}})) mis_cnt_d = mis_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  // Outputs decode straight from the state flop, so an async reset clears them at once
  assign in_redir       = (state_q == ST_REDIR);
  assign redirect_valid = in_redir;
  assign flush_if       = in_redir;
  assign flush_id       = in_redir;
  assign redirect_pc    = in_redir ? redirect_pc_q : 32'd0;
  assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed steps plus a randomized phase,
// all compared against a plain behavioural model of the predictor and redirect sequence.
module tb_branch_predict_ctrl;

  localparam int IDX_W = 6;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [31:0]      lookup_pc;
  logic             pred_taken;
  logic             ex_valid;
  logic             ex_is_branch;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic             ex_taken;
  logic             stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_if;
  logic             flush_id;
  logic [CNT_W-1:0] mispredict_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model: counter strengths as integers 0..3, and a simple redirect timeline
  int          m_ctr [64];
  bit          m_redir;
  bit          m_recover;
  logic [31:0] m_rpc;
  int          m_cnt;

  branch_predict_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_pc      (lookup_pc),
    .pred_taken     (pred_taken),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_taken       (ex_taken),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_redir   = 0;
    m_recover = 0;
    m_rpc     = 32'd0;
    m_cnt     = 0;
  endfunction

  function automatic bit modelPredict(input logic [31:0] pc);
    return m_ctr[pc[7:2]] >= 2;
  endfunction

  // One clock of the reference behaviour, applied at the rising edge
  function automatic void modelStep(input bit v, input bit b, input logic [31:0] pc,
                                    input logic [31:0] tgt, input bit pt, input bit tk,
                                    input bit st);
    int idx;
    if (m_redir) begin
      if (!st) begin
        m_redir   = 0;
        m_recover = 1;
      end
    end else if (m_recover) begin
      m_recover = 0;
    end else if (v && b && !st) begin
      idx = int'(pc[7:2]);
      if (tk) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
      else    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      if (pt != tk) begin
        m_redir = 1;
        m_rpc   = tk ? tgt : pc + 32'd4;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
  endfunction

  task automatic checkRegistered();
    checkOutput("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir});
    checkOutput("flush_if", {31'd0, flush_if}, {31'd0, m_redir});
    checkOutput("flush_id", {31'd0, flush_id}, {31'd0, m_redir});
    checkOutput("redirect_pc", redirect_pc, m_redir ? m_rpc : 32'd0);
    checkOutput("mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt));
  endtask

  // Drive one cycle of inputs just after a falling edge, check the lookup before the
  // rising edge (pre-update value), then check registered outputs at the next falling edge.
  task automatic applyStimulus(input bit v, input bit b, input logic [31:0] pc,
                               input logic [31:0] tgt, input bit pt, input bit tk,
                               input bit st, input logic [31:0] lpc);
    ex_valid      = v;
    ex_is_branch  = b;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pt;
    ex_taken      = tk;
    stall         = st;
    lookup_pc     = lpc;
    #1;
    checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, modelPredict(lpc)});
    @(posedge clk);
    modelStep(v, b, pc, tgt, pt, tk, st);
    @(negedge clk);
    checkRegistered();
  endtask

  task automatic idleStep(input logic [31:0] lpc);
    applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 0, lpc);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] rtgt;
    modelReset();
    rst = 1'b0;
    ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_target = 0;
    ex_pred_taken = 0; ex_taken = 0; stall = 0; lookup_pc = 32'h100;

    // Reset state
    #22;
    checkOutput("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkRegistered();
    @(negedge clk);
    rst = 1'b1;
    idleStep(32'h100);

    // Training towards taken at 0x40, then saturation and one not-taken step
    applyStimulus(1, 1, 32'h40, 32'h400, 1, 1, 0, 32'h40);
    applyStimulus(1, 1, 32'h40, 32'h400, 1, 1, 0, 32'h40);
    idleStep(32'h40);
    applyStimulus(1, 1, 32'h40, 32'h400, 1, 1, 0, 32'h40);
    applyStimulus(1, 1, 32'h40, 32'h400, 0, 0, 0, 32'h40);
    idleStep(32'h40);

    // Mispredict taken, then not-taken with ex_pc+4 wrapping to zero
    applyStimulus(1, 1, 32'h80, 32'h200, 0, 1, 0, 32'h80);
    idleStep(32'h80);
    idleStep(32'h80);
    applyStimulus(1, 1, 32'hFFFF_FFFC, 32'h1234, 1, 0, 0, 32'hFFFF_FFFC);
    idleStep(32'h0);
    idleStep(32'h0);

    // Stall held in REDIR for 3 cycles; a branch offered during RECOVER is ignored
    applyStimulus(1, 1, 32'h90, 32'h300, 0, 1, 0, 32'h90);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'h90, 32'h300, 0, 1, 1, 32'h90);
    applyStimulus(1, 1, 32'h94, 32'h500, 0, 1, 0, 32'h94);
    applyStimulus(1, 1, 32'h94, 32'h500, 0, 1, 0, 32'h94);
    idleStep(32'h94);

    // Stall in IDLE: no training, then the re-presented branch counts once
    applyStimulus(1, 1, 32'hA0, 32'h600, 0, 1, 1, 32'hA0);
    applyStimulus(1, 1, 32'hA0, 32'h600, 0, 1, 0, 32'hA0);
    idleStep(32'hA0);
    idleStep(32'hA0);

    // Collision: same index looked up while being trained
    applyStimulus(1, 1, 32'h140, 32'h0, 0, 0, 0, 32'h40);
    applyStimulus(1, 1, 32'h40, 32'h0, 1, 1, 0, 32'h1040);

    // Randomized phase over a small PC pool so entries get revisited
    for (int n = 0; n < 300; n++) begin
      rpc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 3), 22'd0, $urandom_range(0, 15), 2'b00};
      rtgt = $urandom & 32'hFFFF_FFFC;
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, rpc, rtgt,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0, {$urandom_range(0, 3), 24'd0, $urandom_range(0, 15), 2'b00});
    end

    // Async reset while in REDIR clears outputs before any clock edge
    while (m_redir || m_recover) idleStep(32'h0);
    applyStimulus(1, 1, 32'hC0, 32'h700, 0, 1, 0, 32'hC0);
    checkOutput("pre_reset_redirect", {31'd0, redirect_valid}, 32'd1);
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("async_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("async_flush_if", {31'd0, flush_if}, 32'd0);
    checkOutput("async_redirect_pc", redirect_pc, 32'd0);
    checkOutput("async_mispredict_cnt", 32'(mispredict_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idleStep(32'h40);
    applyStimulus(1, 1, 32'h40, 32'h0, 1, 0, 0, 32'h40);
    idleStep(32'h0);
    idleStep(32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
